// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target and the benches that drive it.
//   DEFAULT_TARGET_ADDR : 7-bit bus address used when no override is given
//   i2c_state_t         : target protocol states
package i2c_pkg;

    localparam logic [6:0] DEFAULT_TARGET_ADDR = 7'h68;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        WAIT_STOP
    } i2c_state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// Bus front end for the I2C target: two-flop synchronizers on SCL and SDA,
// one extra registered copy of each for edge detection, and START/STOP
// recognition.
//   clk, rst   : system clock, synchronous active-high reset
//   scl, sda   : raw bus levels
//   scl_rise   : synced SCL 0->1 (suppressed if SDA moved in the same cycle)
//   scl_fall   : synced SCL 1->0 (suppressed if SDA moved in the same cycle)
//   start_det  : synced SDA 1->0 while synced SCL is high
//   stop_det   : synced SDA 0->1 while synced SCL is high
//   sda_sync   : synchronized SDA level
module i2c_bus_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_sync
);

    // [0] metastability flop, [1] synchronized level, [2] previous level
    logic [2:0] scl_pipe;
    logic [2:0] sda_pipe;
    logic       sda_moved;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_pipe <= '1;
            sda_pipe <= '1;
        end else begin
            scl_pipe <= {scl_pipe[1:0], scl};
            sda_pipe <= {sda_pipe[1:0], sda};
        end
    end

    assign sda_moved = sda_pipe[1] ^ sda_pipe[2];
    assign sda_sync  = sda_pipe[1];

    // An SCL edge coinciding with an SDA edge is only a START/STOP candidate
    assign scl_rise  =  scl_pipe[1] & ~scl_pipe[2] & ~sda_moved;
    assign scl_fall  = ~scl_pipe[1] &  scl_pipe[2] & ~sda_moved;
    assign start_det =  scl_pipe[1] &  sda_pipe[2] & ~sda_pipe[1];
    assign stop_det  =  scl_pipe[1] & ~sda_pipe[2] &  sda_pipe[1];

endmodule

// File: rtl/i2c_target.sv
// I2C target (slave) responding to one 7-bit address. Write bytes are
// delivered on o_rx_byte/o_rx_dataval; read bytes are requested with
// o_tx_req and taken from i_tx_byte. SCL is never driven; SDA is open-drain.
//   i_clk, i_rst  : system clock, synchronous active-high reset
//   i2c_scl       : bus clock input
//   i2c_sda       : bus data, driven low or released
//   o_start/o_stop: one-cycle pulses on START (incl. repeated) / STOP
//   o_busy        : high from an address match until the next START/STOP
//   o_rx_dataval  : one-cycle pulse, o_rx_byte holds a new written byte
//   o_rx_byte     : last written byte
//   o_rx_first    : qualifies o_rx_dataval, first data byte after address
//   o_tx_req      : one-cycle pulse requesting the next read byte
//   i_tx_byte     : read data, latched on the SCL fall after o_tx_req
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = DEFAULT_TARGET_ADDR
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i2c_scl,
    inout  wire        i2c_sda,
    output logic       o_start,
    output logic       o_stop,
    output logic       o_busy,
    output logic       o_rx_dataval,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_first,
    output logic       o_tx_req,
    input  logic [7:0] i_tx_byte
);

    logic       scl_rise;
    logic       scl_fall;
    logic       start_det;
    logic       stop_det;
    logic       sda_sync;

    i2c_state_t state;
    logic [2:0] bit_cnt;
    logic [6:0] rx_shift;
    logic [6:0] tx_shift;     // remaining read bits after the one on the bus
    logic       sda_oe;       // 1 = pull SDA low
    logic       rw;
    logic       first_flag;
    logic       rx_pend;
    logic       ack_seen;

    i2c_bus_sync u_sync (
        .clk       (i_clk),
        .rst       (i_rst),
        .scl       (i2c_scl),
        .sda       (i2c_sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_sync  (sda_sync)
    );

    assign i2c_sda = sda_oe ? 1'b0 : 1'bz;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            rx_shift     <= '0;
            tx_shift     <= '0;
            sda_oe       <= 1'b0;
            rw           <= 1'b0;
            first_flag   <= 1'b0;
            rx_pend      <= 1'b0;
            ack_seen     <= 1'b0;
            o_start      <= 1'b0;
            o_stop       <= 1'b0;
            o_busy       <= 1'b0;
            o_rx_dataval <= 1'b0;
            o_rx_byte    <= '0;
            o_rx_first   <= 1'b0;
            o_tx_req     <= 1'b0;
        end else begin
            o_start      <= 1'b0;
            o_stop       <= 1'b0;
            o_tx_req     <= 1'b0;
            rx_pend      <= 1'b0;
            // Data valid trails the o_rx_byte load by one cycle
            o_rx_dataval <= rx_pend;
            if (rx_pend) begin
                o_rx_first <= first_flag;
                first_flag <= 1'b0;
            end

            if (start_det) begin
                state   <= ADDR;
                bit_cnt <= 3'd7;
                sda_oe  <= 1'b0;
                o_busy  <= 1'b0;
                o_start <= 1'b1;
            end else if (stop_det) begin
                state   <= IDLE;
                sda_oe  <= 1'b0;
                o_busy  <= 1'b0;
                o_stop  <= 1'b1;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise) begin
                            rx_shift <= {rx_shift[5:0], sda_sync};
                            if (bit_cnt == 3'd0) begin
                                // rx_shift holds address bits, sda_sync is R/W
                                if (rx_shift == TARGET_ADDR) begin
                                    state      <= ADDR_ACK;
                                    o_busy     <= 1'b1;
                                    rw         <= sda_sync;
                                    first_flag <= 1'b1;
                                end else begin
                                    state <= WAIT_STOP;
                                end
                            end else begin
                                bit_cnt <= bit_cnt - 3'd1;
                            end
                        end
                    end

                    ADDR_ACK: begin
                        // sda_oe distinguishes the fall that starts the ACK
                        // from the fall that ends it
                        if (scl_rise && rw && sda_oe) begin
                            o_tx_req <= 1'b1;
                        end
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else if (rw) begin
                                tx_shift <= i_tx_byte[6:0];
                                sda_oe   <= ~i_tx_byte[7];
                                bit_cnt  <= 3'd7;
                                state    <= RD_DATA;
                            end else begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= 3'd7;
                                state   <= WR_DATA;
                            end
                        end
                    end

                    WR_DATA: begin
                        if (scl_rise) begin
                            rx_shift <= {rx_shift[5:0], sda_sync};
                            if (bit_cnt == 3'd0) begin
                                o_rx_byte <= {rx_shift, sda_sync};
                                rx_pend   <= 1'b1;
                                state     <= WR_ACK;
                            end else begin
                                bit_cnt <= bit_cnt - 3'd1;
                            end
                        end
                    end

                    WR_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= 3'd7;
                                state   <= WR_DATA;
                            end
                        end
                    end

                    RD_DATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == 3'd0) begin
                                sda_oe   <= 1'b0;
                                ack_seen <= 1'b0;
                                state    <= RD_ACK;
                            end else begin
                                sda_oe   <= ~tx_shift[6];
                                tx_shift <= {tx_shift[5:0], 1'b0};
                                bit_cnt  <= bit_cnt - 3'd1;
                            end
                        end
                    end

                    RD_ACK: begin
                        // ACK requests the next byte; it is loaded on the
                        // following fall together with driving its MSB
                        if (scl_rise) begin
                            if (!sda_sync) begin
                                o_tx_req <= 1'b1;
                                ack_seen <= 1'b1;
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end
                        if (scl_fall && ack_seen) begin
                            tx_shift <= i_tx_byte[6:0];
                            sda_oe   <= ~i_tx_byte[7];
                            bit_cnt  <= 3'd7;
                            state    <= RD_DATA;
                        end
                    end

                    default: begin
                        // IDLE and WAIT_STOP leave only via START/STOP
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
`timescale 1ns/1ps
module tb_i2c_target;
    import i2c_pkg::*;

    // 50 MHz system clock, 100 kHz bus: 500 clocks per bit, 4 quarters
    localparam int Q = 125;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       scl_low;
    logic       sda_low;
    logic [7:0] i_tx_byte;
    logic       o_start, o_stop, o_busy, o_rx_dataval, o_rx_first, o_tx_req;
    logic [7:0] o_rx_byte;
    wire        scl_bus;
    wire        sda_bus;

    always #10 i_clk = ~i_clk;

    // Open-drain bus with pull-ups
    assign scl_bus = scl_low ? 1'b0 : 1'bz;
    assign sda_bus = sda_low ? 1'b0 : 1'bz;
    pullup (scl_bus);
    pullup (sda_bus);

    i2c_target #(.TARGET_ADDR(DEFAULT_TARGET_ADDR)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i2c_scl      (scl_bus),
        .i2c_sda      (sda_bus),
        .o_start      (o_start),
        .o_stop       (o_stop),
        .o_busy       (o_busy),
        .o_rx_dataval (o_rx_dataval),
        .o_rx_byte    (o_rx_byte),
        .o_rx_first   (o_rx_first),
        .o_tx_req     (o_tx_req),
        .i_tx_byte    (i_tx_byte)
    );

    // Event monitor
    int         n_start = 0, n_stop = 0, n_tx = 0, n_rx = 0, n_busy = 0, n_tgt_low = 0;
    logic [7:0] rx_log [64];
    logic       rx_first_log [64];

    always @(negedge i_clk) begin
        if (o_start) n_start++;
        if (o_stop) n_stop++;
        if (o_tx_req) n_tx++;
        if (o_busy) n_busy++;
        if (!sda_low && sda_bus === 1'b0) n_tgt_low++;
        if (o_rx_dataval) begin
            rx_log[n_rx % 64]       = o_rx_byte;
            rx_first_log[n_rx % 64] = o_rx_first;
            n_rx++;
        end
    end

    int total = 0;
    int bad = 0;

    // Reference model: which bytes the target should accept
    logic       m_wr;
    logic       m_first;
    logic [8:0] exp_rx [$];
    int         s_start, s_stop, s_tx, s_busy, s_low, s_rx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wq(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic mark();
        s_start = n_start; s_stop = n_stop; s_tx = n_tx;
        s_busy = n_busy; s_low = n_tgt_low; s_rx = n_rx;
        exp_rx.delete();
    endtask

    task automatic bus_start();
        sda_low = 1'b0; wq(Q);
        scl_low = 1'b0; wq(Q);
        sda_low = 1'b1; wq(Q);
        scl_low = 1'b1; wq(Q);
    endtask

    task automatic bus_stop();
        sda_low = 1'b1; wq(Q);
        scl_low = 1'b0; wq(Q);
        sda_low = 1'b0; wq(Q);
    endtask

    task automatic put_bit(input logic b);
        sda_low = !b;   wq(Q);
        scl_low = 1'b0; wq(2 * Q);
        scl_low = 1'b1; wq(Q);
    endtask

    task automatic get_bit(output logic b);
        sda_low = 1'b0; wq(Q);
        scl_low = 1'b0; wq(Q);
        b = sda_bus;    wq(Q);
        scl_low = 1'b1; wq(Q);
    endtask

    task automatic addr_phase(input string tag, input logic [7:0] a);
        logic ack;
        logic hit;
        hit = (a[7:1] == DEFAULT_TARGET_ADDR);
        for (int i = 7; i >= 0; i--) put_bit(a[i]);
        get_bit(ack);
        chk(tag, ack, !hit);
        m_wr    = hit && !a[0];
        m_first = 1'b1;
    endtask

    task automatic wr_byte(input string tag, input logic [7:0] b);
        logic ack;
        for (int i = 7; i >= 0; i--) put_bit(b[i]);
        get_bit(ack);
        chk(tag, ack, !m_wr);
        if (m_wr) begin
            exp_rx.push_back({m_first, b});
            m_first = 1'b0;
        end
    endtask

    task automatic rd_byte(input string tag, input logic [7:0] exp, input logic nack,
                           input logic [7:0] next_tx);
        logic [7:0] v;
        logic       b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            v[i] = b;
        end
        chk(tag, v, exp);
        i_tx_byte = next_tx;
        put_bit(nack);
    endtask

    task automatic check_rx(input string tag);
        int got;
        got = n_rx - s_rx;
        chk({tag, "_rx_count"}, got, exp_rx.size());
        for (int i = 0; i < got && i < exp_rx.size(); i++) begin
            chk({tag, "_rx_byte"}, rx_log[(s_rx + i) % 64], exp_rx[i][7:0]);
            chk({tag, "_rx_first"}, rx_first_log[(s_rx + i) % 64], exp_rx[i][8]);
        end
    endtask

    initial begin
        logic [7:0] rb;
        logic [7:0] ra;

        i_rst = 1'b1; scl_low = 1'b0; sda_low = 1'b0; i_tx_byte = '0;
        m_wr = 1'b0; m_first = 1'b0;
        wq(5);
        chk("rst_busy", o_busy, 0);
        chk("rst_rx_byte", o_rx_byte, 8'h00);
        chk("rst_pulses", {o_start, o_stop, o_rx_dataval, o_tx_req}, 4'b0000);
        chk("rst_sda", sda_bus, 1);
        i_rst = 1'b0;
        wq(10);
        chk("rst_no_start", n_start, 0);

        // Write: D0, 00, 45
        mark();
        bus_start();
        addr_phase("wr_addr_ack", 8'hD0);
        chk("wr_busy", o_busy, 1);
        wr_byte("wr_ack0", 8'h00);
        wr_byte("wr_ack1", 8'h45);
        bus_stop();
        wq(10);
        check_rx("wr");
        chk("wr_starts", n_start - s_start, 1);
        chk("wr_stops", n_stop - s_stop, 1);
        chk("wr_busy_after", o_busy, 0);
        chk("wr_tx_req", n_tx - s_tx, 0);

        // Read: D1, 12 (ACK), 34 (NACK)
        mark();
        i_tx_byte = 8'h12;
        bus_start();
        addr_phase("rd_addr_ack", 8'hD1);
        rd_byte("rd_byte0", 8'h12, 1'b0, 8'h34);
        rd_byte("rd_byte1", 8'h34, 1'b1, 8'hFF);
        wq(Q);
        chk("rd_sda_released", sda_bus, 1);
        bus_stop();
        wq(10);
        chk("rd_tx_req", n_tx - s_tx, 2);
        chk("rd_stops", n_stop - s_stop, 1);
        chk("rd_busy_after", o_busy, 0);
        check_rx("rd");

        // Address mismatch
        mark();
        bus_start();
        addr_phase("mm_addr_nack", 8'hA0);
        wr_byte("mm_data_nack", 8'h55);
        bus_stop();
        wq(10);
        chk("mm_target_low", n_tgt_low - s_low, 0);
        chk("mm_busy_cycles", n_busy - s_busy, 0);
        chk("mm_tx_req", n_tx - s_tx, 0);
        check_rx("mm");

        // Repeated start: write 07, then read one random byte
        mark();
        rb = 8'($urandom);
        bus_start();
        addr_phase("rs_wr_addr", 8'hD0);
        wr_byte("rs_wr_ack", 8'h07);
        i_tx_byte = rb;
        bus_start();
        addr_phase("rs_rd_addr", 8'hD1);
        rd_byte("rs_rd_byte", rb, 1'b1, 8'h00);
        bus_stop();
        wq(10);
        check_rx("rs");
        chk("rs_starts", n_start - s_start, 2);
        chk("rs_tx_req", n_tx - s_tx, 1);
        chk("rs_stops", n_stop - s_stop, 1);

        // Abort after 4 data bits
        mark();
        rb = 8'($urandom);
        bus_start();
        addr_phase("ab_addr_ack", 8'hD0);
        for (int i = 7; i >= 4; i--) put_bit(rb[i]);
        bus_stop();
        wq(10);
        check_rx("ab");
        chk("ab_busy", o_busy, 0);
        chk("ab_sda", sda_bus, 1);
        chk("ab_stops", n_stop - s_stop, 1);

        // Reset while the target drives the write ACK
        mark();
        rb = 8'($urandom);
        bus_start();
        addr_phase("rr_addr_ack", 8'hD0);
        for (int i = 7; i >= 0; i--) put_bit(rb[i]);
        exp_rx.push_back({1'b1, rb});
        sda_low = 1'b0;
        wq(4);
        chk("rr_ack_driven", sda_bus, 0);
        @(negedge i_clk) i_rst = 1'b1;
        @(negedge i_clk);
        chk("rr_sda_released", sda_bus, 1);
        i_rst = 1'b0;
        chk("rr_busy", o_busy, 0);
        wq(Q);
        bus_stop();
        wq(10);
        check_rx("rr");
        chk("rr_stops", n_stop - s_stop, 1);

        // Random write: matching or random address, one random byte
        mark();
        ra = ($urandom_range(0, 1) == 1) ? 8'hD0 : {7'($urandom), 1'b0};
        rb = 8'($urandom);
        bus_start();
        addr_phase("rnd_addr", ra);
        wr_byte("rnd_data", rb);
        bus_stop();
        wq(10);
        check_rx("rnd");
        chk("rnd_busy_after", o_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
